max_value_uart_tx: RTL and testbench
====================================

MAX_VALUE_UART_TX -- requirements
Module: max_value_uart_tx

Parameters
REQ-001 SHALL have CLKS_PER_BIT, default 243, clk cycles per UART bit (28 MHz / 115200 baud).
REQ-002 SHALL have CPB_WIDTH, default 8, bit width of the baud counter; CLKS_PER_BIT must be ≤ 2^CPB_WIDTH.

Interface
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request one report sweep; sampled only in IDLE.
REQ-006 SHALL have port Max_Value  input  10  cached peak of the currently selected channel.
REQ-007 SHALL have port Max_Value_Channel_sel  output  3  channel select: 3'b001..3'b100 = ch1..ch4; 3'b000 = none.
REQ-008 SHALL have port Tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port Busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port Done  output  1  one-cycle pulse at sweep completion.

Function
REQ-011 SHALL implement the states IDLE, SETTLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-012 SHALL, in IDLE: Tx=1, Busy=0, Max_Value_Channel_sel=0.
REQ-013 SHALL, when Start=1 in IDLE, move at the next edge to SETTLE with Max_Value_Channel_sel=1 and Busy=1.
REQ-014 SHALL hold SETTLE for exactly 1 cycle, capture Max_Value into a 10-bit hold register at the end of that cycle, then move to START_BIT.
REQ-015 SHALL hold that capture for both bytes of the channel; Max_Value changes after SETTLE SHALL NOT affect the transmitted data.
REQ-016 SHALL send two bytes per channel, high byte first: {1'b0, sel[2:0], 2'b00, hold[9:8]}, then hold[7:0].
REQ-017 SHALL frame every byte as START_BIT (Tx=0), then DATA_BITS (8 bits, bit 0 first), then STOP_BIT (Tx=1), each bit lasting exactly CLKS_PER_BIT cycles.
REQ-018 SHALL reload the baud counter to 0 at every bit boundary and advance the bit index 0..7 within DATA_BITS.
REQ-019 SHALL, after the STOP_BIT of the high byte, go directly to START_BIT of the low byte with no idle gap.
REQ-020 SHALL, after the STOP_BIT of the low byte for channels 1..3, increment sel and return to SETTLE.
REQ-021 SHALL, after the low byte of channel 4, send the terminator byte 8'h0A with no SETTLE cycle; sel stays 3'b100 during this byte.
REQ-022 SHALL, after the terminator STOP_BIT, return to IDLE, pulse Done=1 for that single IDLE cycle and drop Busy and sel to 0 in the same cycle.
REQ-023 SHALL make a sweep last exactly 4 + 90*CLKS_PER_BIT cycles, from the first cycle Busy=1 to the last cycle Busy=1.
REQ-024 SHALL ignore Start while Busy=1, with no queuing.
REQ-025 SHALL, when Start=1 in the Done cycle, begin a new sweep at the next edge.
REQ-026 SHALL keep Tx glitch-free: a registered output that changes only at bit boundaries.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, force state IDLE, Tx=1, Busy=0, Done=0, sel=0, and clear the counters and hold register.
REQ-028 SHALL let reset override Start when both are high at the same edge, with no sweep started.
REQ-029 SHALL, on reset mid-byte, truncate the frame and return Tx high at the next edge, with no Done pulse.

Verification
REQ-030 SHALL cover a basic sweep: CLKS_PER_BIT=4, Max_Value per sel ch1=10'h3FF, ch2=10'h000, ch3=10'h155, ch4=10'h2AA, one Start pulse -> decoded bytes 13,FF,20,00,31,55,42,AA,0A; Busy high 364 cycles; one Done.
REQ-031 SHALL cover capture hold: Max_Value changes 10'h001 -> 10'h3FE during ch1 DATA_BITS -> ch1 bytes remain 10,01.
REQ-032 SHALL cover Start while busy: pulse Start at cycle 100 of a sweep -> exactly 9 bytes sent and 1 Done.
REQ-033 SHALL cover back-to-back sweeps: Start held high -> second sweep Busy rises the cycle after Done, 18 bytes total, no idle bit between sweeps beyond the Done cycle.
REQ-034 SHALL cover reset mid-operation: reset asserted during ch3 DATA_BITS -> next edge Tx=1, Busy=0, sel=0, Done never asserts, and a following Start gives a clean full sweep.
REQ-035 SHALL cover bit timing: every Tx bit measured is exactly CLKS_PER_BIT cycles wide, and the start bit of the first byte begins one cycle after Busy rises.

Source files
------------

// File: rtl/max_value_uart_tx.sv
// Peak-value reporter: sweeps channels 1..4, sending each cached 10-bit peak as two
// 8N1 UART bytes (channel tag + high bits, then low bits), followed by a 0x0A terminator.
module max_value_uart_tx #(
  parameter int CLKS_PER_BIT = 243,
  parameter int CPB_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [9:0] Max_Value,
  output logic [2:0] Max_Value_Channel_sel,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETTLE    = 3'd1;
  localparam logic [2:0] START_BIT = 3'd2;
  localparam logic [2:0] DATA_BITS = 3'd3;
  localparam logic [2:0] STOP_BIT  = 3'd4;

  localparam logic [1:0] BYTE_HI   = 2'd0;
  localparam logic [1:0] BYTE_LO   = 2'd1;
  localparam logic [1:0] BYTE_TERM = 2'd2;

  localparam logic [CPB_WIDTH-1:0] CNT_LAST = CPB_WIDTH'(CLKS_PER_BIT - 1);

  logic [2:0]           state_q, state_d;
  logic [CPB_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           byte_q, byte_d;
  logic [2:0]           sel_q, sel_d;
  logic [9:0]           hold_q, hold_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic [7:0]           cur_byte;
  logic                 bit_tick;

  always_comb begin
    case (byte_q)
      BYTE_HI: cur_byte = {1'b0, sel_q, 2'b00, hold_q[9:8]};
      BYTE_LO: cur_byte = hold_q[7:0];
      default: cur_byte = 8'h0A;
    endcase
  end

  assign bit_tick = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (Start) begin
          state_d = SETTLE;
          sel_d   = 3'd1;
          byte_d  = BYTE_HI;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        // Mux output has had a full cycle to settle on the new channel.
        hold_d  = Max_Value;
        state_d = START_BIT;
        tx_d    = 1'b0;
        cnt_d   = '0;
      end
      START_BIT: begin
        if (bit_tick) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA_BITS;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      DATA_BITS: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      STOP_BIT: begin
        if (bit_tick) begin
          cnt_d = '0;
          case (byte_q)
            BYTE_HI: begin
              byte_d  = BYTE_LO;
              state_d = START_BIT;
              tx_d    = 1'b0;
            end
            BYTE_LO: begin
              if (sel_q == 3'd4) begin
                byte_d  = BYTE_TERM;
                state_d = START_BIT;
                tx_d    = 1'b0;
              end else begin
                sel_d   = sel_q + 3'd1;
                byte_d  = BYTE_HI;
                state_d = SETTLE;
              end
            end
            default: begin
              state_d = IDLE;
              done_d  = 1'b1;
              sel_d   = 3'd0;
              byte_d  = BYTE_HI;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CPB_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= BYTE_HI;
      sel_q   <= 3'd0;
      hold_q  <= 10'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign Max_Value_Channel_sel = sel_q;
  assign Tx                    = tx_q;
  assign Busy                  = (state_q != IDLE);
  assign Done                  = done_q;

endmodule

// File: tb/tb_max_value_uart_tx.sv
// Bench for max_value_uart_tx: table-driven sweeps plus corner sequences, with a UART
// monitor that decodes Tx and checks each byte against a scoreboard queue.
`timescale 1ns/1ps
module tb_max_value_uart_tx;
  localparam int CPB       = 4;
  localparam int SWEEP_LEN = 4 + 90 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic [9:0] Max_Value;
  logic [2:0] sel;
  logic       Tx, Busy, Done;

  logic [9:0] mv [4];
  logic [7:0] exp_q [$];
  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int last_busy_len = 0;
  int byte_no = 0;

  typedef struct {
    logic [39:0] vals;
    logic [71:0] exp;
  } vec_t;
  vec_t tbl [4];

  max_value_uart_tx #(.CLKS_PER_BIT(CPB), .CPB_WIDTH(3)) dut (
    .clk(clk), .reset(rst), .Start(Start), .Max_Value(Max_Value),
    .Max_Value_Channel_sel(sel), .Tx(Tx), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      3'd1:    Max_Value = mv[0];
      3'd2:    Max_Value = mv[1];
      3'd3:    Max_Value = mv[2];
      3'd4:    Max_Value = mv[3];
      default: Max_Value = 10'h000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Done === 1'b1) done_cnt++;
    if (rst) busy_cnt = 0;
    else if (Busy === 1'b1) busy_cnt++;
    else if (busy_cnt != 0) begin
      last_busy_len = busy_cnt;
      busy_cnt = 0;
    end
  end

  // UART decoder: samples every cycle of every bit so width errors show up too.
  logic [9:0] mon_bits;
  logic       mon_abort, mon_width_ok;
  logic [7:0] mon_exp;
  always begin
    @(negedge clk);
    if (!rst && Tx === 1'b0) begin
      mon_abort = 1'b0;
      mon_width_ok = 1'b1;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (rst) mon_abort = 1'b1;
          if (k == 0) mon_bits[b] = Tx;
          else if (Tx !== mon_bits[b]) mon_width_ok = 1'b0;
        end
      end
      if (!mon_abort) begin
        chk("start_bit", 32'(mon_bits[0]), 32'd0);
        chk("stop_bit", 32'(mon_bits[9]), 32'd1);
        chk("bit_width", 32'(mon_width_ok), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(mon_bits[8:1]), 32'h100);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("byte %0d: got %02h, expected %02h", byte_no, mon_bits[8:1], mon_exp);
          chk("byte_value", 32'(mon_bits[8:1]), 32'(mon_exp));
        end
        byte_no++;
      end
    end
  end

  task automatic set_vals(input logic [39:0] v);
    for (int c = 0; c < 4; c++) mv[c] = v[39 - 10*c -: 10];
  endtask

  task automatic push_table(input logic [71:0] e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(e[71 - 8*i -: 8]);
  endtask

  task automatic push_model();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back({1'b0, 3'(c + 1), 2'b00, mv[c][9:8]});
      exp_q.push_back(mv[c][7:0]);
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (Done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (Done !== 1'b1) chk({name, "_done_timeout"}, 32'(Done), 32'd1);
  endtask

  task automatic finish_sweep(input string name, input int d0);
    wait_done(name);
    chk({name, "_done_busy"}, 32'(Busy), 32'd0);
    chk({name, "_done_sel"}, 32'(sel), 32'd0);
    @(negedge clk);
    chk({name, "_busy_len"}, 32'(last_busy_len), 32'(SWEEP_LEN));
    chk({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    tbl[0].vals = {10'h3FF, 10'h000, 10'h155, 10'h2AA};
    tbl[0].exp  = 72'h13_FF_20_00_31_55_42_AA_0A;
    tbl[1].vals = {10'h000, 10'h3FF, 10'h2AA, 10'h155};
    tbl[1].exp  = 72'h10_00_23_FF_32_AA_41_55_0A;
    tbl[2].vals = {10'h123, 10'h0FF, 10'h200, 10'h07E};
    tbl[2].exp  = 72'h11_23_20_FF_32_00_40_7E_0A;
    tbl[3].vals = {10'h001, 10'h100, 10'h300, 10'h3C3};
    tbl[3].exp  = 72'h10_01_21_00_33_00_43_C3_0A;

    rst = 1'b1;
    Start = 1'b0;
    set_vals(40'd0);
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(Tx), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Start latency and first start bit position
    set_vals(tbl[0].vals);
    push_table(tbl[0].exp, 9);
    d0 = done_cnt;
    pulse_start();
    chk("start_busy", 32'(Busy), 32'd1);
    chk("start_sel", 32'(sel), 32'd1);
    chk("settle_tx", 32'(Tx), 32'd1);
    @(negedge clk);
    chk("first_start_bit", 32'(Tx), 32'd0);
    finish_sweep("timing", d0);

    for (int i = 0; i < 4; i++) begin
      set_vals(tbl[i].vals);
      push_table(tbl[i].exp, 9);
      d0 = done_cnt;
      pulse_start();
      finish_sweep($sformatf("vec%0d", i), d0);
      repeat (3) @(negedge clk);
    end

    // Capture hold: ch1 input changes mid data bits
    set_vals({10'h001, 10'h0C5, 10'h2F0, 10'h10F});
    push_model();
    d0 = done_cnt;
    pulse_start();
    repeat (10) @(negedge clk);
    mv[0] = 10'h3FE;
    finish_sweep("hold", d0);

    // Start while busy is ignored
    set_vals(tbl[2].vals);
    push_table(tbl[2].exp, 9);
    d0 = done_cnt;
    pulse_start();
    repeat (99) @(negedge clk);
    chk("busy_at_100", 32'(Busy), 32'd1);
    pulse_start();
    wait_done("ignore");
    repeat (420) @(negedge clk);
    chk("ignore_done_count", 32'(done_cnt - d0), 32'd1);
    chk("ignore_bytes_left", 32'(exp_q.size()), 32'd0);
    chk("ignore_idle", 32'(Busy), 32'd0);

    // Back-to-back sweeps with Start held
    set_vals(tbl[1].vals);
    push_table(tbl[1].exp, 9);
    push_table(tbl[1].exp, 9);
    d0 = done_cnt;
    Start = 1'b1;
    @(negedge clk);
    wait_done("b2b_first");
    chk("b2b_done_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    chk("b2b_restart_busy", 32'(Busy), 32'd1);
    chk("b2b_restart_sel", 32'(sel), 32'd1);
    Start = 1'b0;
    finish_sweep("b2b_second", d0 + 1);

    // Reset during ch3 data bits
    set_vals(tbl[0].vals);
    push_table(tbl[0].exp, 4);
    d0 = done_cnt;
    pulse_start();
    repeat (174) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 32'(Tx), 32'd1);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_bytes_left", 32'(exp_q.size()), 32'd0);
    set_vals(tbl[3].vals);
    push_table(tbl[3].exp, 9);
    d0 = done_cnt;
    pulse_start();
    finish_sweep("after_rst", d0);

    // Reset wins over Start at the same edge
    rst = 1'b1;
    Start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    Start = 1'b0;
    chk("rst_start_busy", 32'(Busy), 32'd0);
    @(negedge clk);
    chk("rst_start_busy2", 32'(Busy), 32'd0);
    chk("rst_start_tx", 32'(Tx), 32'd1);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
